restoring_divider_8bit: RTL and testbench
=========================================

Name: restoring_divider_8bit

Overview:
- Sequential restoring divider: the inverse of the team's 4x4->8 Vedic multiplier.
- Takes a DATA_WIDTH-bit dividend and a DATA_WIDTH/2-bit divisor and produces a DATA_WIDTH-bit quotient and a DATA_WIDTH/2-bit remainder.
- Resolves one quotient bit per clock.
- Valid/ready handshakes on both sides, so it sits behind the matrix datapath for normalisation/averaging steps.

Parameters:
- DATA_WIDTH, 8: dividend and quotient width. Divisor and remainder are DATA_WIDTH/2. Must be even and >= 4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- inValid  input  1  operands valid.
- inReady  output  1  block can accept operands.
- inData_A  input  DATA_WIDTH  dividend (unsigned).
- inData_B  input  DATA_WIDTH/2  divisor (unsigned).
- outValid  output  1  result valid.
- outReady  input  1  downstream accepts result.
- outData_Q  output  DATA_WIDTH  quotient.
- outData_R  output  DATA_WIDTH/2  remainder.
- outDivZero  output  1  divisor was zero.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; inReady=0 while rst high, 1 from the first edge after release.
  - outValid=0, outData_Q=0, outData_R=0, outDivZero=0; all internal registers and counter cleared.
- States: IDLE, CALC, DONE. inReady=1 only in IDLE. outValid=1 only in DONE.
- IDLE:
  - On an edge with inValid&&inReady: latch dividend into the shift register and the divisor into a register.
  - Clear partial remainder (DATA_WIDTH/2+1 bits). Set counter=DATA_WIDTH-1. Go to CALC.
- CALC, each edge:
  - Shift {rem, dividend} left by 1.
  - trial = rem_shifted - {1'b0,divisor}.
  - If trial is non-negative (MSB=0): rem=trial, quotient bit=1. Else: rem unchanged, bit=0.
  - Quotient bits fill the vacated dividend LSBs, MSB first.
  - When counter==0, go to DONE; otherwise decrement.
- Latency:
  - Handshake at edge N gives outValid=1 after edge N+DATA_WIDTH (8 cycles at default).
  - Latency is fixed and independent of operand values, including divide-by-zero.
- DONE:
  - outData_Q, outData_R and outDivZero are held stable while outValid=1 && outReady=0.
  - On an edge with outReady=1: go to IDLE and drop outValid.
  - outData_* keep their last values until the next DONE; their value is only defined while outValid=1.
  - Throughput is one result per DATA_WIDTH+2 cycles minimum (one IDLE bubble).
- Divide-by-zero (divisor latched as 0):
  - Iteration still runs for the full latency.
  - In DONE, force outData_Q = all ones, outData_R = dividend[DATA_WIDTH/2-1:0], outDivZero=1.
  - outDivZero=0 for every nonzero divisor.
- Input stability:
  - inData_* are sampled only at the accepting edge.
  - Changes while not in IDLE are ignored. inValid outside IDLE is ignored, with no queueing.
- Arithmetic:
  - Unsigned only. The remainder always satisfies R < divisor, so it fits DATA_WIDTH/2 bits.
  - The quotient cannot overflow DATA_WIDTH bits.
- Reset mid-operation: rst asserted in CALC or DONE aborts immediately to IDLE with the reset values above. No result is emitted.
- Simultaneous events:
  - outReady is ignored outside DONE.
  - The DONE->IDLE edge does not accept new operands, because inReady is 0 during DONE.

Test Plan:
- Basic division: A=200, B=7 -> after 8 cycles outValid=1, Q=28, R=4, outDivZero=0.
- Edge values:
  - A=255, B=15 -> Q=17, R=0.
  - A=5, B=9 -> Q=0, R=5.
  - A=0, B=1 -> Q=0, R=0.
- Divide-by-zero: A=13, B=0 -> latency 8, Q=255, R=13, outDivZero=1. Then A=13, B=1 -> Q=13, outDivZero=0.
- Backpressure:
  - Hold outReady=0 for 5 cycles after outValid -> Q/R stable and inReady=0 throughout.
  - inValid with new operands during this time is not accepted.
  - Release -> IDLE next edge, then the next division completes correctly.
- Reset mid-CALC: assert rst 3 cycles after accepting A=100, B=3 -> outValid=0 and inReady=0 during reset, no result emitted. After release, A=100, B=3 -> Q=33, R=1.
- Random sweep: 1000 random A/B with random outReady stalls, checked against Q=A/B, R=A%B (divide-by-zero rule for B=0). Latency is exactly 8 every time.

Source files
------------

// File: rtl/restoring_divider_8bit.sv
// Sequential restoring divider: DATA_WIDTH-bit dividend / DATA_WIDTH/2-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
module restoring_divider_8bit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic [DATA_WIDTH-1:0]     inData_A,
  input  logic [DATA_WIDTH/2-1:0]   inData_B,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [DATA_WIDTH-1:0]     outData_Q,
  output logic [DATA_WIDTH/2-1:0]   outData_R,
  output logic                      outDivZero
);

  localparam int HW = DATA_WIDTH / 2;
  localparam int CW = $clog2(DATA_WIDTH);

  // state | meaning
  // IDLE  | waiting for operands, inReady=1
  // CALC  | one quotient bit resolved per edge
  // DONE  | result presented, waiting for outReady
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] dvd;
  logic [HW:0]           rem;
  logic [HW-1:0]         dsr;
  logic [HW-1:0]         dvd_low;
  logic [CW-1:0]         cnt;
  logic                  ready_en;

  logic                  accept;
  logic                  last_bit;
  logic [HW:0]           rem_shift;
  logic [HW:0]           trial;
  logic                  q_bit;
  logic [HW:0]           rem_next;

  // ready_en keeps inReady low until the first edge after reset release
  assign inReady  = (state == IDLE) && ready_en;
  assign outValid = (state == DONE);
  assign accept   = inValid && inReady;
  assign last_bit = (state == CALC) && (cnt == '0);

  // trial MSB set means the subtraction went negative; remainder is restored
  assign rem_shift = {rem[HW-1:0], dvd[DATA_WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dsr};
  assign q_bit     = ~trial[HW];
  assign rem_next  = q_bit ? trial : rem_shift;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (outReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en <= 1'b0;
      dvd      <= '0;
      rem      <= '0;
      dsr      <= '0;
      dvd_low  <= '0;
      cnt      <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        dvd     <= inData_A;
        dsr     <= inData_B;
        dvd_low <= inData_A[HW-1:0];
        rem     <= '0;
        cnt     <= CW'(DATA_WIDTH - 1);
      end else if (state == CALC) begin
        dvd <= {dvd[DATA_WIDTH-2:0], q_bit};
        rem <= rem_next;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end

  // Results are captured once, on the edge that enters DONE, so they stay put under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outData_Q  <= '0;
      outData_R  <= '0;
      outDivZero <= 1'b0;
    end else if (last_bit) begin
      if (dsr == '0) begin
        outData_Q  <= '1;
        outData_R  <= dvd_low;
        outDivZero <= 1'b1;
      end else begin
        outData_Q  <= {dvd[DATA_WIDTH-2:0], q_bit};
        outData_R  <= rem_next[HW-1:0];
        outDivZero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// Directed and random checks of restoring_divider_8bit against an arithmetic reference model.
module tb_restoring_divider_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       inValid;
  logic       inReady;
  logic [7:0] inData_A;
  logic [3:0] inData_B;
  logic       outValid;
  logic       outReady;
  logic [7:0] outData_Q;
  logic [3:0] outData_R;
  logic       outDivZero;

  int n_cmp  = 0;
  int n_fail = 0;

  restoring_divider_8bit #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .inValid(inValid), .inReady(inReady),
    .inData_A(inData_A), .inData_B(inData_B),
    .outValid(outValid), .outReady(outReady),
    .outData_Q(outData_Q), .outData_R(outData_R), .outDivZero(outDivZero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned division, divide-by-zero yields all ones and the dividend's low half
  task automatic ref_div(input int a, input int b, output int q, output int r, output int dz);
    if (b == 0) begin
      q = 255; r = a % 16; dz = 1;
    end else begin
      q = a / b; r = a % b; dz = 0;
    end
  endtask

  task automatic do_div(input int a, input int b, input int stall, input string tag);
    int q, r, dz, lat;
    ref_div(a, b, q, r, dz);
    @(negedge clk);
    check({tag, ".in_ready"}, inReady, 1);
    inValid  = 1'b1;
    inData_A = 8'(a);
    inData_B = 4'(b);
    @(posedge clk);
    #1;
    inValid  = 1'b0;
    inData_A = 8'($urandom);
    inData_B = 4'($urandom);
    lat = 0;
    while (outValid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, lat, 8);
    check({tag, ".q"}, outData_Q, q);
    check({tag, ".r"}, outData_R, r);
    check({tag, ".dz"}, outDivZero, dz);
    for (int i = 0; i < stall; i++) begin
      inValid  = 1'b1;
      inData_A = 8'($urandom);
      inData_B = 4'($urandom);
      @(posedge clk);
      #1;
      check({tag, ".stall_valid"}, outValid, 1);
      check({tag, ".stall_ready"}, inReady, 0);
      check({tag, ".stall_q"}, outData_Q, q);
      check({tag, ".stall_r"}, outData_R, r);
      check({tag, ".stall_dz"}, outDivZero, dz);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    check({tag, ".drop_valid"}, outValid, 0);
    check({tag, ".back_idle"}, inReady, 1);
  endtask

  initial begin
    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    inData_A = '0;
    inData_B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", inReady, 0);
    check("rst.out_valid", outValid, 0);
    check("rst.q", outData_Q, 0);
    check("rst.r", outData_R, 0);
    check("rst.dz", outDivZero, 0);
    @(negedge clk);
    rst = 1'b0;
    check("rel.in_ready_low", inReady, 0);
    @(posedge clk);
    #1;
    check("rel.in_ready_high", inReady, 1);

    do_div(200, 7, 0, "basic");
    do_div(255, 15, 0, "max");
    do_div(5, 9, 0, "small");
    do_div(0, 1, 0, "zero_a");
    do_div(13, 0, 0, "div0");
    do_div(13, 1, 0, "after_div0");
    do_div(77, 6, 5, "backpressure");
    do_div(250, 11, 0, "after_bp");

    // Abort mid-calculation with reset
    @(negedge clk);
    inValid  = 1'b1;
    inData_A = 8'd100;
    inData_B = 4'd3;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst.out_valid", outValid, 0);
    check("mid_rst.in_ready", inReady, 0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst.hold_ready", inReady, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("mid_rst.no_result", outValid, 0);
    end
    do_div(100, 3, 0, "post_rst");

    for (int i = 0; i < 1000; i++) begin
      do_div(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
